// File: rtl/dual_issue_scoreboard.sv
// Register scoreboard and in-order dual-issue controller.
// Per-register countdowns keep in-flight destinations busy until their result lands.
module dual_issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             slot0_valid,
    input  logic [4:0]       slot0_rd,
    input  logic [4:0]       slot0_rs1,
    input  logic [4:0]       slot0_rs2,
    input  logic             slot0_uses_rs2,
    input  logic [LAT_W-1:0] slot0_lat,
    input  logic             slot1_valid,
    input  logic [4:0]       slot1_rd,
    input  logic [4:0]       slot1_rs1,
    input  logic [4:0]       slot1_rs2,
    input  logic             slot1_uses_rs2,
    input  logic [LAT_W-1:0] slot1_lat,
    output logic             issue0,
    output logic             issue1,
    output logic             stall,
    output logic [NREG-1:0]  busy_mask,
    output logic [NREG-1:0]  retire_mask,
    output logic [5:0]       outstanding
);

    logic [NREG-1:0][LAT_W-1:0] counter_q, counter_d;
    logic [NREG-1:0]            busy_mask_q, busy_mask_d;
    logic [NREG-1:0]            retire_mask_q, retire_mask_d;
    logic [5:0]                 outstanding_q, outstanding_d;
    logic [LAT_W-1:0]           lat0_eff, lat1_eff;
    logic                       src0_ok, src1_ok, pair_raw, pair_waw;

    // Busy state comes straight from the registered mask: no same-cycle bypass.
    always_comb begin
        src0_ok  = ~busy_mask_q[slot0_rs1]
                 & (~slot0_uses_rs2 | ~busy_mask_q[slot0_rs2])
                 & ~busy_mask_q[slot0_rd];
        src1_ok  = ~busy_mask_q[slot1_rs1]
                 & (~slot1_uses_rs2 | ~busy_mask_q[slot1_rs2])
                 & ~busy_mask_q[slot1_rd];
        pair_raw = (slot0_rd != 5'd0)
                 & ((slot0_rd == slot1_rs1) | (slot1_uses_rs2 & (slot0_rd == slot1_rs2)));
        pair_waw = (slot0_rd != 5'd0) & (slot0_rd == slot1_rd);
        issue0   = en & ~flush & slot0_valid & src0_ok;
        issue1   = issue0 & slot1_valid & src1_ok & ~pair_raw & ~pair_waw;
        stall    = slot0_valid & ~issue0;
        lat0_eff = (slot0_lat == '0) ? LAT_W'(1) : slot0_lat;
        lat1_eff = (slot1_lat == '0) ? LAT_W'(1) : slot1_lat;
    end

    always_comb begin
        counter_d     = counter_q;
        retire_mask_d = '0;
        busy_mask_d   = '0;
        outstanding_d = '0;
        if (flush) begin
            counter_d = '0;
        end else if (en) begin
            for (int r = 0; r < NREG; r++) begin
                if (counter_q[r] != '0) begin
                    counter_d[r] = counter_q[r] - LAT_W'(1);
                    if (counter_q[r] == LAT_W'(1))
                        retire_mask_d[r] = 1'b1;
                end
                // The WAW guard guarantees a load never hits a decrementing counter.
                if (r != 0 && issue0 && slot0_rd == 5'(r))
                    counter_d[r] = lat0_eff;
                if (r != 0 && issue1 && slot1_rd == 5'(r))
                    counter_d[r] = lat1_eff;
            end
        end
        for (int r = 0; r < NREG; r++) begin
            busy_mask_d[r] = (counter_d[r] != '0);
            outstanding_d  = outstanding_d + 6'(busy_mask_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q     <= '0;
            busy_mask_q   <= '0;
            retire_mask_q <= '0;
            outstanding_q <= '0;
        end else begin
            counter_q     <= counter_d;
            busy_mask_q   <= busy_mask_d;
            retire_mask_q <= retire_mask_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign busy_mask   = busy_mask_q;
    assign retire_mask = retire_mask_q;
    assign outstanding = outstanding_q;

endmodule

// File: doc/dual_issue_scoreboard.md
# dual_issue_scoreboard

Register scoreboard and issue controller for the two-slot datapath. It sits between the instruction queue and the two ALU datapaths and the dual-write register file. Each cycle it decides which of the two queued instructions may issue, based on source/destination busy state and intra-pair hazards. It tracks every in-flight destination register with a per-register countdown, so multi-cycle results are never read early or overwritten out of order.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero
- LAT_W, 3, width of the latency field; maximum latency is 2^LAT_W-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  tick enable from the clock divider; state advances only on edges where en=1
- flush  in  1  synchronous clear of all in-flight state
- slot0_valid  in  1  older queued instruction present
- slot0_rd, slot0_rs1, slot0_rs2  in  5 each  destination/source register indices
- slot0_uses_rs2  in  1  rs2 is a real operand (0 for immediate forms)
- slot0_lat  in  LAT_W  en-cycles rd stays busy after issue; 0 is treated as 1
- slot1_valid, slot1_rd, slot1_rs1, slot1_rs2, slot1_uses_rs2, slot1_lat  in  as slot0  younger instruction
- issue0, issue1  out  1 each  combinational grants; the datapath executes and the queue pops on these
- stall  out  1  slot0_valid & ~issue0 (queue freeze)
- busy_mask  out  NREG  registered; bit r = counter[r] != 0
- retire_mask  out  NREG  registered one-en-cycle pulses; bit r = rd r completed
- outstanding  out  6  registered popcount of busy_mask

## Operation
- State: counter[r] (LAT_W bits) for r=1..NREG-1; counter[0] constant 0, so busy_mask[0]=0 and retire_mask[0]=0 always.
- issue0 = en & ~flush & slot0_valid & ~busy[rs1_0] & (~uses_rs2_0 | ~busy[rs2_0]) & ~busy[rd_0]. The last term is the WAW guard.
- issue1 = issue0 & slot1_valid & ~busy[rs1_1] & (~uses_rs2_1 | ~busy[rs2_1]) & ~busy[rd_1] & ~pairRAW & ~pairWAW.
  - pairRAW: rd_0 != 0 and (rd_0 == rs1_1 or (uses_rs2_1 and rd_0 == rs2_1)).
  - pairWAW: rd_0 != 0 and rd_0 == rd_1.
- Issue is strictly in order: slot1 never issues without slot0.
- Busy checks use the current registered state only. There is no bypass: a register whose counter is 1 this cycle still counts as busy.
- Update on each edge with en=1 and no flush/rst, for every r:
  - if counter[r] != 0: counter[r] decrements, and retire_mask[r] is set when it goes 1 to 0.
  - if issue0 and rd_0 == r != 0: counter[r] loads max(slot0_lat, 1).
  - if issue1 and rd_1 == r != 0: counter[r] loads max(slot1_lat, 1).
  - Load and decrement never collide, because the WAW guard forbids issue to a busy rd.
- rd = 0 issues normally but marks nothing.
- en=0: counters hold; retire_mask clears to 0; issue0 = issue1 = 0.
- flush=1 on any edge: all counters, busy_mask, retire_mask and outstanding go to 0. flush has priority over issue and decrement, and issue outputs are 0 while flush=1.
- outstanding = number of nonzero counters after the update, range 0..31.

## Timing
- Reset values: every counter 0, busy_mask 0, retire_mask 0, outstanding 0. issue0, issue1 and stall are combinational and read 0 while slot valids are 0.
- Issue has zero latency: the grant appears in the same cycle as valid inputs, from registered state.
- For an instruction issued in en-cycle k with lat = L:
  - busy_mask[rd] is high for en-cycles k+1 .. k+L.
  - retire_mask[rd] pulses in cycle k+L+1.
  - The earliest dependent issue is in cycle k+L+1.
- With L=1, a back-to-back dependent instruction incurs exactly one stall cycle.
- rst has priority over everything and acts on any clk edge regardless of en. Reset in the middle of a countdown abandons it with no retire pulse.
- Flush behaves the same as rst: no retire pulses are produced for abandoned registers.

## Test plan
- Reset, then slot0 = (rd=5, rs1=1, rs2=2, lat=3) and slot1 = (rd=6, rs1=3, imm) -> issue0 = issue1 = 1; busy_mask = 0x60 for 3 cycles; retire_mask = 0x60 in the 4th; outstanding 2 then 0.
- Pair RAW: slot0 rd=7, slot1 rs1=7 -> issue0=1, issue1=0. On the next cycle, with slot1 shifted to slot0 and lat=1: stall=1 for one cycle, then issue0=1.
- Pair WAW rd_0 = rd_1 = 9 -> issue1=0. Pair with rd_0 = rd_1 = 0 -> both issue; busy_mask stays 0.
- en toggling 1,0,0,1 during a lat=2 countdown on r4 -> counter holds while en=0; retire_mask[4] pulses only on the second en=1 edge; issue outputs are 0 during en=0.
- flush asserted with 3 registers busy and issue0 requested -> issue0=0 that cycle; busy_mask, outstanding and retire_mask are 0 next cycle; no retire pulse.
- lat=0 and lat=7 on r31 -> behave as 1 and 7 respectively. A dependent on r31 stalls exactly 1 and 7 cycles.
